// File: rtl/ifmap_stream_packer.sv
// Packs PAR_WRITE row-tagged IF-map pixels into one wide IF FIFO word.
// At end of frame it zero-pads the final pack and pulses frame_done once that pack is written.
module ifmap_stream_packer #(
    parameter int IF_WIDTH  = 16,
    parameter int PAR_WRITE = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IF_WIDTH-3:0]           in_data,
    input  logic                          in_start,
    input  logic                          in_end,
    input  logic                          in_last,
    input  logic                          buf_full,
    output logic                          buf_wen,
    output logic [IF_WIDTH*PAR_WRITE-1:0] buf_din,
    output logic                          frame_done,
    output logic [CNT_WIDTH-1:0]          pix_count
);

    localparam int IDX_W = (PAR_WRITE > 1) ? $clog2(PAR_WRITE) : 1;

    typedef enum logic {FILL, PUSH} state_t;

    state_t                                 state_q, state_d;
    logic [IDX_W-1:0]                       idx_q, idx_d;
    logic [PAR_WRITE-1:0][IF_WIDTH-1:0]     lanes_q, lanes_d;
    logic                                   last_q, last_d;
    logic                                   done_q, done_d;
    logic [CNT_WIDTH-1:0]                   cnt_q, cnt_d;

    assign in_ready   = (state_q == FILL);
    assign buf_wen    = (state_q == PUSH) & ~buf_full;
    assign buf_din    = lanes_q;
    assign frame_done = done_q;
    assign pix_count  = cnt_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lanes_d = lanes_q;
        last_d  = last_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    lanes_d[idx_q] = {in_start, in_end, in_data};
                    cnt_d          = cnt_q + 1'b1;
                    if (in_last) begin
                        // Short final pack: pad the unfilled upper lanes with zeros.
                        for (int i = 0; i < PAR_WRITE; i++)
                            if (i > int'(idx_q)) lanes_d[i] = '0;
                        last_d  = 1'b1;
                        state_d = PUSH;
                    end else if (idx_q == IDX_W'(PAR_WRITE - 1)) begin
                        state_d = PUSH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PUSH: begin
                if (!buf_full) begin
                    state_d = FILL;
                    idx_d   = '0;
                    lanes_d = '0;
                    done_d  = last_q;
                    last_d  = 1'b0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            state_q <= FILL;
            idx_q   <= '0;
            lanes_q <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
            last_q  <= last_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ifmap_stream_packer.sv
// Directed bench for ifmap_stream_packer with PAR_WRITE=4, IF_WIDTH=16.
// Inputs are driven and outputs sampled on the falling edge.
module tb_ifmap_stream_packer;

    localparam int IFW = 16;
    localparam int PW  = 4;
    localparam int CW  = 16;

    logic              clk = 1'b0;
    logic              rst, clr, in_valid, in_ready;
    logic [IFW-3:0]    in_data;
    logic              in_start, in_end, in_last, buf_full, buf_wen, frame_done;
    logic [IFW*PW-1:0] buf_din;
    logic [CW-1:0]     pix_count;

    int errors = 0;
    int checks = 0;

    ifmap_stream_packer #(.IF_WIDTH(IFW), .PAR_WRITE(PW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_start(in_start), .in_end(in_end), .in_last(in_last),
        .buf_full(buf_full), .buf_wen(buf_wen), .buf_din(buf_din),
        .frame_done(frame_done), .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one pixel for one clock; the packer must be ready for it.
    task automatic send(input logic [IFW-3:0] d, input logic s, input logic e, input logic l);
        chk("send_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; in_data = d; in_start = s; in_end = e; in_last = l;
        @(negedge clk);
        in_valid = 1'b0; in_start = 1'b0; in_end = 1'b0; in_last = 1'b0; in_data = '0;
    endtask

    initial begin
        logic [63:0] held;
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
        in_start = 1'b0; in_end = 1'b0; in_last = 1'b0; buf_full = 1'b0;

        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wen",   {63'd0, buf_wen}, 64'd0);
        chk("rst_din",   buf_din, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_cnt",   {48'd0, pix_count}, 64'd0);
        chk("rst_done",  {63'd0, frame_done}, 64'd0);

        // Full pack with row tags
        send(14'h11, 1'b1, 1'b0, 1'b0);
        send(14'h22, 1'b0, 1'b0, 1'b0);
        send(14'h33, 1'b0, 1'b0, 1'b0);
        send(14'h44, 1'b0, 1'b1, 1'b0);
        chk("full_wen",   {63'd0, buf_wen}, 64'd1);
        chk("full_din",   buf_din, 64'h4044_0033_0022_8011);
        chk("full_ready", {63'd0, in_ready}, 64'd0);
        chk("full_cnt",   {48'd0, pix_count}, 64'd4);
        @(negedge clk);
        chk("full_after_ready", {63'd0, in_ready}, 64'd1);
        chk("full_after_wen",   {63'd0, buf_wen}, 64'd0);
        chk("full_after_din",   buf_din, 64'd0);
        chk("full_no_done",     {63'd0, frame_done}, 64'd0);

        // in_last without in_valid is ignored
        in_last = 1'b1;
        @(negedge clk);
        in_last = 1'b0;
        chk("lastnv_ready", {63'd0, in_ready}, 64'd1);
        chk("lastnv_cnt",   {48'd0, pix_count}, 64'd4);

        // Back-pressure: FIFO full for 5 cycles
        buf_full = 1'b1;
        send(14'h11, 1'b1, 1'b0, 1'b0);
        send(14'h22, 1'b0, 1'b0, 1'b0);
        send(14'h33, 1'b0, 1'b0, 1'b0);
        send(14'h44, 1'b0, 1'b1, 1'b0);
        held = 64'h4044_0033_0022_8011;
        for (int i = 0; i < 5; i++) begin
            chk("bp_wen",   {63'd0, buf_wen}, 64'd0);
            chk("bp_din",   buf_din, held);
            chk("bp_ready", {63'd0, in_ready}, 64'd0);
            if (i < 4) @(negedge clk);
        end
        buf_full = 1'b0;
        #1;
        chk("bp_release_wen", {63'd0, buf_wen}, 64'd1);
        chk("bp_release_din", buf_din, held);
        @(negedge clk);
        chk("bp_after_ready", {63'd0, in_ready}, 64'd1);
        chk("bp_cnt",         {48'd0, pix_count}, 64'd8);

        // Partial flush: 6 pixels, last one ends the frame
        send(14'd1, 1'b0, 1'b0, 1'b0);
        send(14'd2, 1'b0, 1'b0, 1'b0);
        send(14'd3, 1'b0, 1'b0, 1'b0);
        send(14'd4, 1'b0, 1'b0, 1'b0);
        chk("pf_w1_wen", {63'd0, buf_wen}, 64'd1);
        chk("pf_w1_din", buf_din, 64'h0004_0003_0002_0001);
        @(negedge clk);
        send(14'd5, 1'b0, 1'b0, 1'b0);
        send(14'd6, 1'b0, 1'b0, 1'b1);
        chk("pf_w2_wen",  {63'd0, buf_wen}, 64'd1);
        chk("pf_w2_din",  buf_din, 64'h0000_0000_0006_0005);
        chk("pf_w2_done", {63'd0, frame_done}, 64'd0);
        @(negedge clk);
        chk("pf_done",    {63'd0, frame_done}, 64'd1);
        chk("pf_ready",   {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        chk("pf_done_off", {63'd0, frame_done}, 64'd0);
        chk("pf_cnt",      {48'd0, pix_count}, 64'd14);

        // Exact multiple: 8 pixels, no padding
        for (int i = 0; i < 4; i++) send(14'(16 + i), 1'b0, 1'b0, 1'b0);
        chk("em_w1_wen",  {63'd0, buf_wen}, 64'd1);
        chk("em_w1_din",  buf_din, 64'h0013_0012_0011_0010);
        chk("em_w1_done", {63'd0, frame_done}, 64'd0);
        @(negedge clk);
        chk("em_gap_done", {63'd0, frame_done}, 64'd0);
        for (int i = 4; i < 8; i++) send(14'(16 + i), 1'b0, 1'b0, i == 7);
        chk("em_w2_wen", {63'd0, buf_wen}, 64'd1);
        chk("em_w2_din", buf_din, 64'h0017_0016_0015_0014);
        @(negedge clk);
        chk("em_done", {63'd0, frame_done}, 64'd1);
        @(negedge clk);
        chk("em_done_off", {63'd0, frame_done}, 64'd0);
        chk("em_cnt",      {48'd0, pix_count}, 64'd22);

        // clr while stalled in PUSH drops the pack
        buf_full = 1'b1;
        send(14'h21, 1'b0, 1'b0, 1'b0);
        send(14'h22, 1'b0, 1'b0, 1'b0);
        send(14'h23, 1'b0, 1'b0, 1'b1);
        chk("clr_pre_wen",   {63'd0, buf_wen}, 64'd0);
        chk("clr_pre_ready", {63'd0, in_ready}, 64'd0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        buf_full = 1'b0;
        chk("clr_ready", {63'd0, in_ready}, 64'd1);
        chk("clr_cnt",   {48'd0, pix_count}, 64'd0);
        chk("clr_din",   buf_din, 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("clr_wen",  {63'd0, buf_wen}, 64'd0);
            chk("clr_done", {63'd0, frame_done}, 64'd0);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifmap_stream_packer.md
Name: ifmap_stream_packer

Overview:
- Upstream feeder for the IF-map input FIFO of the convolution datapath.
- Accepts one IF-map pixel per cycle over a valid/ready stream, tags each pixel with row start/end flags, and packs PAR_WRITE tagged words into one wide word.
- Writes the wide word into the IF FIFO (PAR_WRITE lanes, IF_WIDTH bits each) under the FIFO's full back-pressure.
- Also handles end-of-frame flush with zero padding.

Parameters:
- IF_WIDTH, 16, tagged word width; bit IF_WIDTH-1 = row start flag, bit IF_WIDTH-2 = row end flag, bits IF_WIDTH-3:0 = pixel.
- PAR_WRITE, 16, lanes per FIFO write; must be >= 2.
- CNT_WIDTH, 16, width of the accepted-pixel counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- clr  in  1  synchronous clear; same effect as reset; reset has priority.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  packer can accept a pixel this cycle.
- in_data  in  IF_WIDTH-2  pixel value.
- in_start  in  1  pixel is the first of an IF-map row.
- in_end  in  1  pixel is the last of an IF-map row.
- in_last  in  1  pixel is the last of the frame.
- buf_full  in  1  IF FIFO full.
- buf_wen  out  1  IF FIFO write enable.
- buf_din  out  IF_WIDTH*PAR_WRITE  packed word; lane i = bits [i*IF_WIDTH +: IF_WIDTH].
- frame_done  out  1  one-cycle pulse after the frame's final write.
- pix_count  out  CNT_WIDTH  pixels accepted since reset/clr; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset/clr:
  - State FILL, lane index 0, all lanes 0, pad flag 0.
  - Outputs: buf_wen=0, buf_din=0, frame_done=0, pix_count=0, in_ready=1.
- Accept: a pixel is accepted when in_valid & in_ready.
  - Tagged word {in_start, in_end, in_data} goes to lane[idx].
  - idx increments; pix_count increments.
  - First accepted pixel of a pack goes to lane 0.
- State FILL: in_ready=1, buf_wen=0.
  - Accept with idx==PAR_WRITE-1: move to PUSH next cycle.
  - Accept with in_last=1 at any idx: latch last_flag, zero lanes idx+1..PAR_WRITE-1, move to PUSH.
- State PUSH: in_ready=0.
  - buf_wen = ~buf_full (combinational from registered state and buf_full); buf_din holds stable.
  - While buf_full=1: stay in PUSH; lanes unchanged; wait indefinitely.
  - Cycle with buf_wen=1 (write taken): next cycle state FILL, idx=0, lanes cleared.
  - If last_flag was set: frame_done=1 for exactly that next cycle, then last_flag clears.
- Throughput: a full pack costs PAR_WRITE accept cycles plus at least 1 push cycle. in_ready drops exactly during PUSH.
- Tag bits pass through unchecked; start/end consistency is the producer's responsibility.
- in_start/in_end/in_last are ignored unless the pixel is accepted.
- Frame with pixel count an exact multiple of PAR_WRITE: the final pack has no padding.
- in_last with in_valid=0: ignored.
- clr or rst during PUSH: pending pack is discarded, no write issued, no frame_done.
- pix_count wraps to 0 after 2^CNT_WIDTH-1; no status change.

Test Plan:
- Reset values, PAR_WRITE=4, IF_WIDTH=16: rst=0 two cycles, then release → buf_wen=0, buf_din=0, in_ready=1, pix_count=0, frame_done=0.
- Full pack: pixels 0x0011, 0x0022, 0x0033, 0x0044; first with in_start, last with in_end; buf_full=0.
  - buf_wen=1 the cycle after the 4th accept.
  - buf_din = {16'h4044, 16'h0033, 16'h0022, 16'h8011}.
  - in_ready=0 that cycle; pix_count=4.
- Back-pressure: same pack with buf_full=1 for 5 cycles.
  - buf_wen=0 and buf_din stable for all 5 cycles; in_ready=0.
  - buf_wen=1 on the cycle buf_full falls; in_ready=1 the next cycle.
- Partial flush: 6 pixels 1..6, 6th with in_last.
  - Write 1 = {4,3,2,1}; write 2 = {0,0,6,5}.
  - frame_done=1 exactly one cycle, the cycle after write 2.
- Exact multiple: 8 pixels, 8th with in_last → two writes, no zero lanes, single frame_done pulse.
- Mid-operation clr: clr=1 while in PUSH with buf_full=1 → next cycle state FILL, in_ready=1, pix_count=0; no buf_wen, no frame_done ever issued for the dropped pack.
